// File: rtl/hazard_ctl.sv
// Pipeline sequencing controller: load-use stalls, branch squashes, HALT drain/restart,
// registered P3 operand-forward selects and saturating stall/flush event counters.
module hazard_ctl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             p2_valid,
    input  logic [2:0]       p2_ra,
    input  logic [2:0]       p2_rb,
    input  logic             p2_use_ra,
    input  logic             p2_use_rb,
    input  logic             p2_halt,
    input  logic             p3_regwrite,
    input  logic             p3_memread,
    input  logic [2:0]       p3_wdst,
    input  logic             p4_regwrite,
    input  logic [2:0]       p4_wdst,
    input  logic             br_taken,
    input  logic             restart,
    output logic             pc_en,
    output logic             ph2_en,
    output logic             ph2_flush,
    output logic             ph3_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_P4 = 2'd1;
    localparam logic [1:0] FWD_P5 = 2'd2;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             dcnt_q, dcnt_d;
    logic             halted_q, halted_d;
    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic m3_a, m3_b, m4_a, m4_b, lu;
    logic stall_inc, flush_inc;

    // Operand producer matches; the P3 instruction is newer than the P4 one.
    always_comb begin
        m3_a = p2_valid & p2_use_ra & p3_regwrite & (p2_ra == p3_wdst);
        m3_b = p2_valid & p2_use_rb & p3_regwrite & (p2_rb == p3_wdst);
        m4_a = p2_valid & p2_use_ra & p4_regwrite & (p2_ra == p4_wdst);
        m4_b = p2_valid & p2_use_rb & p4_regwrite & (p2_rb == p4_wdst);
        lu   = p3_memread & (m3_a | m3_b);
    end

    // Next-state and pipeline control decode.
    always_comb begin
        state_d    = state_q;
        dcnt_d     = dcnt_q;
        pc_en      = 1'b0;
        ph2_en     = 1'b0;
        ph2_flush  = 1'b0;
        ph3_bubble = 1'b1;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;

        unique case (state_q)
            S_RUN: begin
                if (br_taken) begin
                    pc_en     = 1'b1;
                    ph2_en    = 1'b1;
                    ph2_flush = 1'b1;
                    flush_inc = 1'b1;
                end else if (p2_valid && p2_halt) begin
                    dcnt_d  = 1'b1;
                    state_d = S_DRAIN;
                end else if (lu) begin
                    stall_inc = 1'b1;
                end else begin
                    pc_en      = 1'b1;
                    ph2_en     = 1'b1;
                    ph3_bubble = 1'b0;
                end
            end
            S_DRAIN: begin
                dcnt_d = dcnt_q - 1'b1;
                if (dcnt_q == 1'b0) begin
                    state_d = S_HALTED;
                end
            end
            S_HALTED: begin
                // Restart discards the HLT in P2 and advances HLT+1 behind a bubble.
                if (restart) begin
                    pc_en   = 1'b1;
                    ph2_en  = 1'b1;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase

        if (!rst_n) begin
            pc_en      = 1'b0;
            ph2_en     = 1'b0;
            ph2_flush  = 1'b1;
            ph3_bubble = 1'b1;
            stall_inc  = 1'b0;
            flush_inc  = 1'b0;
        end
    end

    // Forward selects and counter updates.
    always_comb begin
        fwd_a_d  = FWD_RF;
        fwd_b_d  = FWD_RF;
        halted_d = (state_d == S_HALTED);
        if (!ph3_bubble) begin
            fwd_a_d = m3_a ? FWD_P4 : (m4_a ? FWD_P5 : FWD_RF);
            fwd_b_d = m3_b ? FWD_P4 : (m4_b ? FWD_P5 : FWD_RF);
        end
        stall_d = (stall_inc && stall_q != CNT_MAX) ? stall_q + CNT_W'(1) : stall_q;
        flush_d = (flush_inc && flush_q != CNT_MAX) ? flush_q + CNT_W'(1) : flush_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_RUN;
            dcnt_q   <= 1'b0;
            halted_q <= 1'b0;
            fwd_a_q  <= FWD_RF;
            fwd_b_q  <= FWD_RF;
            stall_q  <= '0;
            flush_q  <= '0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            halted_q <= halted_d;
            fwd_a_q  <= fwd_a_d;
            fwd_b_q  <= fwd_b_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
        end
    end

    assign fwd_a     = fwd_a_q;
    assign fwd_b     = fwd_b_q;
    assign halted    = halted_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_hazard_ctl.sv
// Scoreboard bench for hazard_ctl: a cycle-level reference model queues expected outputs,
// a separate monitor pops and compares them against the DUT every cycle.
module tb_hazard_ctl;

    localparam int CNT_MAX = 65535;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p2_valid, p2_use_ra, p2_use_rb, p2_halt;
    logic [2:0]  p2_ra, p2_rb, p3_wdst, p4_wdst;
    logic        p3_regwrite, p3_memread, p4_regwrite;
    logic        br_taken, restart;
    logic        pc_en, ph2_en, ph2_flush, ph3_bubble, halted;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    hazard_ctl #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .p2_valid(p2_valid), .p2_ra(p2_ra), .p2_rb(p2_rb),
        .p2_use_ra(p2_use_ra), .p2_use_rb(p2_use_rb), .p2_halt(p2_halt),
        .p3_regwrite(p3_regwrite), .p3_memread(p3_memread), .p3_wdst(p3_wdst),
        .p4_regwrite(p4_regwrite), .p4_wdst(p4_wdst),
        .br_taken(br_taken), .restart(restart),
        .pc_en(pc_en), .ph2_en(ph2_en), .ph2_flush(ph2_flush), .ph3_bubble(ph3_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit pc, en, en_chk, fl, bub, hlt;
        int fa, fb, sc, fc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: cycles since HALT was seen (-1 = running, >=3 = halted).
    int since_halt = -1;
    int m_sc = 0, m_fc = 0, m_fa = 0, m_fb = 0;

    function automatic bit needs(input bit use_r);
        return p2_valid && use_r;
    endfunction

    // Newest in-flight producer of register r decides where P3 gets the operand.
    function automatic int source_of(input bit use_r, input logic [2:0] r);
        if (!needs(use_r)) return 0;
        if (p3_regwrite && p3_wdst == r) return 1;
        if (p4_regwrite && p4_wdst == r) return 2;
        return 0;
    endfunction

    function automatic bit waits_on_load(input bit use_r, input logic [2:0] r);
        return needs(use_r) && p3_memread && p3_regwrite && p3_wdst == r;
    endfunction

    task automatic clear_in();
        p2_valid = 0; p2_use_ra = 0; p2_use_rb = 0; p2_halt = 0;
        p2_ra = 0; p2_rb = 0; p3_wdst = 0; p4_wdst = 0;
        p3_regwrite = 0; p3_memread = 0; p4_regwrite = 0;
        br_taken = 0; restart = 0;
    endtask

    // Predict this cycle's outputs, queue them, advance the model across the edge.
    task automatic cycle();
        exp_t e;
        bit running, is_halted, load_use;
        #1;
        running   = (since_halt < 0);
        is_halted = (since_halt >= 3);
        load_use  = waits_on_load(p2_use_ra, p2_ra) || waits_on_load(p2_use_rb, p2_rb);
        e.cyc = cyc; e.hlt = is_halted;
        e.fa = m_fa; e.fb = m_fb; e.sc = m_sc; e.fc = m_fc;
        e.fl = 0; e.en_chk = 1;
        if (!rst_n)                           begin e.pc = 0; e.en = 0; e.fl = 1; e.bub = 1; end
        else if (running && br_taken)         begin e.pc = 1; e.en = 1; e.fl = 1; e.bub = 1; e.en_chk = 0; end
        else if (running && p2_valid && p2_halt) begin e.pc = 0; e.en = 0; e.bub = 1; end
        else if (running && load_use)         begin e.pc = 0; e.en = 0; e.bub = 1; end
        else if (running)                     begin e.pc = 1; e.en = 1; e.bub = 0; end
        else if (is_halted && restart)        begin e.pc = 1; e.en = 1; e.bub = 1; end
        else                                  begin e.pc = 0; e.en = 0; e.bub = 1; end
        sb.push_back(e);

        if (!rst_n) begin
            since_halt = -1; m_sc = 0; m_fc = 0; m_fa = 0; m_fb = 0;
        end else begin
            if (running && br_taken) m_fc = (m_fc < CNT_MAX) ? m_fc + 1 : m_fc;
            else if (running && p2_valid && p2_halt) since_halt = 1;
            else if (running && load_use) m_sc = (m_sc < CNT_MAX) ? m_sc + 1 : m_sc;
            else if (!running) begin
                if (is_halted && restart) since_halt = -1;
                else since_halt = (since_halt < 3) ? since_halt + 1 : 3;
            end
            m_fa = e.bub ? 0 : source_of(p2_use_ra, p2_ra);
            m_fb = e.bub ? 0 : source_of(p2_use_rb, p2_rb);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int cy, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cy, act, exp_v);
        end
    endtask

    // Monitor: every cycle the DUT presents a full output set; compare against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc_en", e.cyc, int'(pc_en), int'(e.pc));
                if (e.en_chk) chk("ph2_en", e.cyc, int'(ph2_en), int'(e.en));
                chk("ph2_flush", e.cyc, int'(ph2_flush), int'(e.fl));
                chk("ph3_bubble", e.cyc, int'(ph3_bubble), int'(e.bub));
                chk("halted", e.cyc, int'(halted), int'(e.hlt));
                chk("fwd_a", e.cyc, int'(fwd_a), e.fa);
                chk("fwd_b", e.cyc, int'(fwd_b), e.fb);
                chk("stall_cnt", e.cyc, int'(stall_cnt), e.sc);
                chk("flush_cnt", e.cyc, int'(flush_cnt), e.fc);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        clear_in();
        @(negedge clk);
        cycle();
        cycle();
        rst_n = 1;
        cycle();

        // Load r1 in P3, ADD in P2 reads r1 via ra: one stall, then forward from P5.
        p2_valid = 1; p2_use_ra = 1; p2_ra = 3'd1;
        p3_regwrite = 1; p3_memread = 1; p3_wdst = 3'd1;
        cycle();
        p3_regwrite = 0; p3_memread = 0;
        p4_regwrite = 1; p4_wdst = 3'd1;
        cycle();
        clear_in();
        cycle();

        // rb producer in both P3 and P4, only P4, then rb not used.
        p2_valid = 1; p2_use_rb = 1; p2_rb = 3'd3;
        p3_regwrite = 1; p3_wdst = 3'd3; p4_regwrite = 1; p4_wdst = 3'd3;
        cycle();
        p3_wdst = 3'd5;
        cycle();
        p2_use_rb = 0;
        cycle();
        clear_in();
        cycle();

        // Branch wins over a simultaneous load-use and over a HLT in P2.
        p2_valid = 1; p2_use_ra = 1; p2_ra = 3'd2;
        p3_regwrite = 1; p3_memread = 1; p3_wdst = 3'd2; br_taken = 1;
        cycle();
        p2_halt = 1;
        cycle();
        clear_in();
        cycle();

        // HLT drain, idle in HALTED, ignored branch, then restart.
        p2_valid = 1; p2_halt = 1;
        cycle();
        clear_in(); br_taken = 1; restart = 1;
        cycle();
        cycle();
        br_taken = 0; restart = 0;
        repeat (5) cycle();
        restart = 1;
        cycle();
        clear_in();
        repeat (2) cycle();

        // Reset while draining returns straight to RUN.
        p2_valid = 1; p2_halt = 1;
        cycle();
        clear_in(); rst_n = 0;
        cycle();
        rst_n = 1;
        repeat (2) cycle();

        // Randomized traffic over a small register window so hazards are frequent.
        for (int i = 0; i < 4000; i++) begin
            rst_n       = ($urandom_range(0, 199) != 0);
            p2_valid    = ($urandom_range(0, 9) != 0);
            p2_use_ra   = $urandom_range(0, 1);
            p2_use_rb   = $urandom_range(0, 1);
            p2_ra       = 3'($urandom_range(0, 3));
            p2_rb       = 3'($urandom_range(0, 3));
            p2_halt     = ($urandom_range(0, 29) == 0);
            p3_regwrite = $urandom_range(0, 1);
            p3_memread  = ($urandom_range(0, 2) == 0);
            p3_wdst     = 3'($urandom_range(0, 3));
            p4_regwrite = $urandom_range(0, 1);
            p4_wdst     = 3'($urandom_range(0, 3));
            br_taken    = ($urandom_range(0, 9) == 0);
            restart     = ($urandom_range(0, 3) == 0);
            cycle();
        end

        // Saturate the stall counter with back-to-back load-use cycles.
        clear_in(); rst_n = 0;
        cycle();
        rst_n = 1;
        p2_valid = 1; p2_use_ra = 1; p2_ra = 3'd6;
        p3_regwrite = 1; p3_memread = 1; p3_wdst = 3'd6;
        repeat (CNT_MAX + 4) cycle();
        clear_in();
        repeat (2) cycle();

        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
